// File: rtl/portal_request_deframer_if.sv
// Request/delivery bus of the portal request deframer.
// slave  : the deframer itself (accepts beats, presents held messages)
// master : the producer/consumer driving beats in and taking messages out
interface portal_request_deframer_if #(
  parameter int MAX_WORDS = 4
);
  logic [31:0]             message_enq_v;
  logic                    EN_message_enq;
  logic                    RDY_message_enq;
  logic                    message_notFull;
  logic [15:0]             deliver_method;
  logic [4:0]              deliver_len;
  logic [32*MAX_WORDS-1:0] deliver_payload;
  logic                    RDY_deliver;
  logic                    EN_deliver;

  modport slave (
    input  message_enq_v, EN_message_enq, EN_deliver,
    output RDY_message_enq, message_notFull, deliver_method, deliver_len,
           deliver_payload, RDY_deliver
  );

  modport master (
    output message_enq_v, EN_message_enq, EN_deliver,
    input  RDY_message_enq, message_notFull, deliver_method, deliver_len,
           deliver_payload, RDY_deliver
  );
endinterface

// File: rtl/portal_request_deframer.sv
// Portal request deframer: turns a beat stream (header + payload words) into
// whole messages held for a consumer.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset
//   bus (slave)  beat input (message_enq_v/EN/RDY/notFull) and held-message
//                output (deliver_method/len/payload, RDY_deliver/EN_deliver)
//   requests_id  constant PORTAL_ID
//   err_pulse    one-cycle pulse after a malformed header is accepted
//   msg_count    delivered messages (wraps), err_count malformed headers (saturates)
module portal_request_deframer #(
  parameter int unsigned PORTAL_ID   = 5,
  parameter int          MAX_WORDS   = 4,
  parameter int          NUM_METHODS = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  portal_request_deframer_if.slave   bus,
  output logic [31:0]                requests_id,
  output logic                       err_pulse,
  output logic [31:0]                msg_count,
  output logic [15:0]                err_count
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, HOLD, DRAIN} state_t;

  state_t                      state, nxt;
  logic [15:0]                 method_q;
  logic [4:0]                  len_q;
  logic [4:0]                  widx;
  logic [15:0]                 remain;   // beats still to discard in DRAIN
  logic [MAX_WORDS-1:0][31:0]  payload_q;

  logic        enq_fire, dlv_fire, hdr_bad;
  logic [15:0] hdr_meth, hdr_len;

  assign enq_fire = bus.EN_message_enq && (state != HOLD);
  assign dlv_fire = bus.EN_deliver && (state == HOLD);
  assign hdr_meth = bus.message_enq_v[31:16];
  assign hdr_len  = bus.message_enq_v[15:0];
  assign hdr_bad  = (hdr_len == 16'd0) || (hdr_len > 16'(MAX_WORDS + 1)) ||
                    (hdr_meth >= 16'(NUM_METHODS));

  // All outputs come from flops (state decode counts as registered).
  assign requests_id         = 32'(PORTAL_ID);
  assign bus.RDY_message_enq = (state != HOLD);
  assign bus.message_notFull = bus.RDY_message_enq;
  assign bus.RDY_deliver     = (state == HOLD);
  assign bus.deliver_method  = method_q;
  assign bus.deliver_len     = len_q;
  assign bus.deliver_payload = payload_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (enq_fire) begin
        if (hdr_bad)               nxt = (hdr_len > 16'd1) ? DRAIN : IDLE;
        else if (hdr_len == 16'd1) nxt = HOLD;
        else                       nxt = PAYLOAD;
      end
      PAYLOAD: if (enq_fire && (widx == len_q - 5'd1)) nxt = HOLD;
      DRAIN:   if (enq_fire && (remain == 16'd1))      nxt = IDLE;
      HOLD:    if (dlv_fire)                           nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      method_q  <= '0;
      len_q     <= '0;
      widx      <= '0;
      remain    <= '0;
      payload_q <= '0;
      err_pulse <= 1'b0;
      msg_count <= '0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: if (enq_fire) begin
          if (hdr_bad) begin
            // Previously delivered message fields are left untouched.
            err_pulse <= 1'b1;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            remain <= hdr_len - 16'd1;
          end else begin
            method_q  <= hdr_meth;
            len_q     <= 5'(hdr_len - 16'd1);
            payload_q <= '0;
            widx      <= '0;
          end
        end
        PAYLOAD: if (enq_fire) begin
          for (int i = 0; i < MAX_WORDS; i++)
            if (widx == 5'(i)) payload_q[i] <= bus.message_enq_v;
          widx <= widx + 5'd1;
        end
        DRAIN: if (enq_fire) remain <= remain - 16'd1;
        HOLD:  if (dlv_fire) msg_count <= msg_count + 32'd1;
        default: ;
      endcase
    end
  end
endmodule
